tt_resp_checker: RTL and testbench

Hardware response checker for small combinational lab modules. On `start` it walks an input vector exhaustively from 0 to 2**N_IN-1 and holds each value for a fixed window. At the end of each window it samples the DUT output `f` and builds the captured truth table. It compares every sample against an expected table latched at start, then reports pass/fail, a mismatch count and the first failing vector. The block sits beside the DUT in self-checking lab tops and replaces hand-written stimulus sequences.

---
 rtl/tt_resp_checker_if.sv | 42 ++++
 rtl/tt_resp_checker.sv | 204 ++++++++++++++++++++
 tb/tb_tt_resp_checker.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_resp_checker_if.sv
// Bundles the stimulus/response signals between a lab top and the response
// checker. The checker takes the slave side; whatever owns the DUT under test
// takes the master side. With TT_STABLE_CHECK_EN defined the extra 'unstable'
// flag is carried as well.
interface tt_resp_checker_if #(
  parameter int N_IN = 3
);
  logic                   start;
  logic [(1<<N_IN)-1:0]   exp_tt;
  logic                   f;
  logic [N_IN-1:0]        x;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [(1<<N_IN)-1:0]   tt;
  logic [N_IN:0]          err_cnt;
  logic [N_IN-1:0]        first_err_vec;
  logic                   first_err_valid;
`ifdef TT_STABLE_CHECK_EN
  logic                   unstable;

  modport master (
    output start, exp_tt, f,
    input  x, busy, done, pass, tt, err_cnt, first_err_vec, first_err_valid, unstable
  );

  modport slave (
    input  start, exp_tt, f,
    output x, busy, done, pass, tt, err_cnt, first_err_vec, first_err_valid, unstable
  );
`else
  modport master (
    output start, exp_tt, f,
    input  x, busy, done, pass, tt, err_cnt, first_err_vec, first_err_valid
  );

  modport slave (
    input  start, exp_tt, f,
    output x, busy, done, pass, tt, err_cnt, first_err_vec, first_err_valid
  );
`endif
endinterface

// File: rtl/tt_resp_checker.sv
// Exhaustive truth-table response checker for small combinational lab DUTs.
// On an accepted start it steps x through 0..2**N_IN-1, holding each vector
// for HOLD_CYCLES cycles and sampling f on the last cycle of each window.
// Samples are compared against the expected table latched at start; the block
// reports the captured table, mismatch count, first failing vector and pass.
// Optional macro TT_STABLE_CHECK_EN: additionally require f to stay constant
// from hold count SETTLE to the end of each window; an unstable window counts
// as a mismatch and raises the sticky 'unstable' output.
module tt_resp_checker #(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 20,
  parameter int SETTLE      = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  tt_resp_checker_if.slave bus
);

  localparam int                TT_W     = 1 << N_IN;
  localparam int                CNT_W    = $clog2(HOLD_CYCLES);
  localparam logic [N_IN-1:0]   VEC_LAST = '1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TT_W-1:0]   expTt_q, expTt_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [N_IN:0]     errCnt_q, errCnt_d;
  logic [N_IN-1:0]   firstErrVec_q, firstErrVec_d;
  logic              firstErrValid_q, firstErrValid_d;
  logic              pass_q, pass_d;

  logic              windowEnd;
  logic              sampleBad;

`ifdef TT_STABLE_CHECK_EN
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE);

  logic              refF_q, refF_d;
  logic              winUnstable_q, winUnstable_d;
  logic              unstable_q, unstable_d;
  logic              unstableNow;

  // f has moved away from the value captured at the settle point
  assign unstableNow = (cnt_q > CNT_SETTLE) && (bus.f != refF_q);
  assign sampleBad   = (bus.f != expTt_q[vec_q]) || winUnstable_q || unstableNow;
  assign bus.unstable = unstable_q;
`else
  // SETTLE only matters for the stability check; referenced here so the
  // parameter list is identical in both builds.
  localparam int unusedSettle = SETTLE;

  assign sampleBad = (bus.f != expTt_q[vec_q]);
`endif

  assign windowEnd = (state_q == HOLD) && (cnt_q == CNT_LAST);

  // State register of the sweep controller
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start only counts in IDLE, the sweep ends after the top vector's window
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = HOLD;
      HOLD:    if (windowEnd && (vec_q == VEC_LAST)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; x is forced to 0 outside a sweep so it never wanders
  always_comb begin
    bus.x    = '0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      HOLD: begin
        bus.x    = vec_q;
        bus.busy = 1'b1;
      end
      FINISH:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: latch on start, sample and score at each window end
  always_comb begin
    vec_d           = vec_q;
    cnt_d           = cnt_q;
    expTt_d         = expTt_q;
    tt_d            = tt_q;
    errCnt_d        = errCnt_q;
    firstErrVec_d   = firstErrVec_q;
    firstErrValid_d = firstErrValid_q;
    pass_d          = pass_q;
`ifdef TT_STABLE_CHECK_EN
    refF_d          = refF_q;
    winUnstable_d   = winUnstable_q;
    unstable_d      = unstable_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          expTt_d         = bus.exp_tt;
          tt_d            = '0;
          errCnt_d        = '0;
          firstErrVec_d   = '0;
          firstErrValid_d = 1'b0;
          pass_d          = 1'b0;
          vec_d           = '0;
          cnt_d           = '0;
`ifdef TT_STABLE_CHECK_EN
          refF_d          = 1'b0;
          winUnstable_d   = 1'b0;
          unstable_d      = 1'b0;
`endif
        end
      end
      HOLD: begin
`ifdef TT_STABLE_CHECK_EN
        if (cnt_q == CNT_SETTLE) refF_d = bus.f;
        if (unstableNow) winUnstable_d = 1'b1;
`endif
        if (windowEnd) begin
          tt_d[vec_q] = bus.f;
          if (sampleBad) begin
            errCnt_d = errCnt_q + (N_IN+1)'(1);
            if (!firstErrValid_q) begin
              firstErrVec_d   = vec_q;
              firstErrValid_d = 1'b1;
            end
          end
`ifdef TT_STABLE_CHECK_EN
          if (winUnstable_q || unstableNow) unstable_d = 1'b1;
          winUnstable_d = 1'b0;
`endif
          cnt_d = '0;
          if (vec_q == VEC_LAST) begin
            pass_d = (errCnt_d == '0);
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any partial sweep results
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vec_q           <= '0;
      cnt_q           <= '0;
      expTt_q         <= '0;
      tt_q            <= '0;
      errCnt_q        <= '0;
      firstErrVec_q   <= '0;
      firstErrValid_q <= 1'b0;
      pass_q          <= 1'b0;
`ifdef TT_STABLE_CHECK_EN
      refF_q          <= 1'b0;
      winUnstable_q   <= 1'b0;
      unstable_q      <= 1'b0;
`endif
    end else begin
      vec_q           <= vec_d;
      cnt_q           <= cnt_d;
      expTt_q         <= expTt_d;
      tt_q            <= tt_d;
      errCnt_q        <= errCnt_d;
      firstErrVec_q   <= firstErrVec_d;
      firstErrValid_q <= firstErrValid_d;
      pass_q          <= pass_d;
`ifdef TT_STABLE_CHECK_EN
      refF_q          <= refF_d;
      winUnstable_q   <= winUnstable_d;
      unstable_q      <= unstable_d;
`endif
    end
  end

  assign bus.pass            = pass_q;
  assign bus.tt              = tt_q;
  assign bus.err_cnt         = errCnt_q;
  assign bus.first_err_vec   = firstErrVec_q;
  assign bus.first_err_valid = firstErrValid_q;

endmodule

// File: tb/tb_tt_resp_checker.sv
// Testbench for tt_resp_checker. A behavioural sweep model (cycle position
// arithmetic plus per-vector sample arrays) predicts every output each cycle;
// directed scenarios add hand-computed literal expectations.
module tb_tt_resp_checker;

  localparam int N_IN   = 3;
  localparam int HOLD   = 20;
  localparam int SETTLE = 2;
  localparam int TT_W   = 8;
  localparam int SWEEP_LAT = TT_W * HOLD + 1;
`ifdef TT_STABLE_CHECK_EN
  localparam bit StableEn = 1'b1;
`else
  localparam bit StableEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fTiedLow = 1'b0;
  logic fGlitch = 1'b0;
  logic checkEn = 1'b0;
  logic trackEn = 1'b0;
  int compared = 0;
  int mismatched = 0;

  tt_resp_checker_if #(.N_IN(N_IN)) bus();

  tt_resp_checker #(
    .N_IN(N_IN),
    .HOLD_CYCLES(HOLD),
    .SETTLE(SETTLE)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Lab DUT stand-in: f = x1&x2 | x3 with x1 = x[2], x3 = x[0]; optionally tied low or glitched
  always_comb begin
    bus.f = (fTiedLow ? 1'b0 : ((bus.x[2] & bus.x[1]) | bus.x[0])) ^ fGlitch;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_RUN, M_FIN} mPhase_e;
  mPhase_e mPhase = M_IDLE;
  int mCycle = 0;
  int mWins = 0;
  logic [TT_W-1:0] mExp = '0;
  logic [TT_W-1:0] mSmp = '0;
  logic [TT_W-1:0] mRefF = '0;
  logic [TT_W-1:0] mUnst = '0;
  bit mFinished = 1'b0;
  int mVec, mPos;

  // Model advance: position in the sweep is derived from cycles since start
  always @(posedge clk) begin
    if (rst) begin
      mPhase = M_IDLE;
      mWins = 0;
      mSmp = '0;
      mUnst = '0;
      mFinished = 1'b0;
    end else begin
      case (mPhase)
        M_IDLE: if (bus.start) begin
          mPhase = M_RUN;
          mExp = bus.exp_tt;
          mCycle = 0;
          mWins = 0;
          mSmp = '0;
          mUnst = '0;
          mFinished = 1'b0;
        end
        M_RUN: begin
          mVec = mCycle / HOLD;
          mPos = mCycle % HOLD;
          if (mPos == SETTLE) mRefF[mVec] = bus.f;
          if (mPos > SETTLE && bus.f != mRefF[mVec]) mUnst[mVec] = 1'b1;
          if (mPos == HOLD - 1) begin
            mSmp[mVec] = bus.f;
            mWins++;
            if (mVec == TT_W - 1) begin
              mPhase = M_FIN;
              mFinished = 1'b1;
            end
          end
          mCycle++;
        end
        default: mPhase = M_IDLE;
      endcase
    end
  end

  logic [TT_W-1:0] eTt;
  logic [3:0] eErr;
  logic [2:0] eFev, eX;
  logic eFevValid, eBad, eUnstable;

  // Compare process: every output against the model, mid-cycle
  always @(negedge clk) begin
    if (checkEn) begin
      eTt = '0; eErr = '0; eFev = '0; eFevValid = 1'b0; eUnstable = 1'b0;
      for (int j = 0; j < mWins; j++) begin
        eTt[j] = mSmp[j];
        eBad = (mSmp[j] != mExp[j]) || (StableEn && mUnst[j]);
        if (mUnst[j]) eUnstable = 1'b1;
        if (eBad) begin
          eErr++;
          if (!eFevValid) begin
            eFev = 3'(j);
            eFevValid = 1'b1;
          end
        end
      end
      eX = (mPhase == M_RUN) ? 3'(mCycle / HOLD) : 3'd0;
      checkOutput("cmp_x", bus.x, eX);
      checkOutput("cmp_busy", bus.busy, mPhase == M_RUN);
      checkOutput("cmp_done", bus.done, mPhase == M_FIN);
      checkOutput("cmp_tt", bus.tt, eTt);
      checkOutput("cmp_err_cnt", bus.err_cnt, eErr);
      checkOutput("cmp_first_err_vec", bus.first_err_vec, eFev);
      checkOutput("cmp_first_err_valid", bus.first_err_valid, eFevValid);
      checkOutput("cmp_pass", bus.pass, mFinished && (eErr == 0));
`ifdef TT_STABLE_CHECK_EN
      checkOutput("cmp_unstable", bus.unstable, eUnstable);
`endif
    end
  end

  // x-stepping tracker: cycles per vector value and any non-unit step
  int runLen[TT_W];
  int stepErr;
  logic [2:0] prevX;
  logic prevBusy;
  always @(negedge clk) begin
    if (!trackEn) begin
      for (int i = 0; i < TT_W; i++) runLen[i] = 0;
      stepErr = 0;
      prevBusy = 1'b0;
      prevX = '0;
    end else begin
      if (bus.busy) begin
        runLen[bus.x]++;
        if (prevBusy && bus.x != prevX && bus.x != prevX + 3'd1) stepErr++;
      end
      prevBusy = bus.busy;
      prevX = bus.x;
    end
  end

  // Pulse start for one cycle; returns just after the edge that accepted it
  task automatic applyStimulus(input logic [TT_W-1:0] expTt);
    @(posedge clk);
    #2;
    bus.exp_tt = expTt;
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
  endtask

  // Latency counts the cycle start was presented in; bounded wait
  task automatic waitDone(output int lat, output bit gotDone);
    lat = 1;
    gotDone = 1'b0;
    for (int i = 0; i < 400 && !gotDone; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) gotDone = 1'b1;
    end
    checkOutput("done_seen", gotDone, 1'b1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_x"}, bus.x, 0);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_done"}, bus.done, 0);
    checkOutput({tag, "_pass"}, bus.pass, 0);
    checkOutput({tag, "_tt"}, bus.tt, 0);
    checkOutput({tag, "_err_cnt"}, bus.err_cnt, 0);
    checkOutput({tag, "_first_err_vec"}, bus.first_err_vec, 0);
    checkOutput({tag, "_first_err_valid"}, bus.first_err_valid, 0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int lat;
  bit gotDone;
  int doneCount;

  // Directed scenarios
  initial begin
    bus.start = 1'b0;
    bus.exp_tt = '0;

    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    #1;
    rst = 1'b0;
    checkEn = 1'b1;

    $display("[TB] matching sweep, exp 8'hEA");
    applyStimulus(8'hEA);
    waitDone(lat, gotDone);
    checkOutput("t1_latency", lat, SWEEP_LAT);
    checkOutput("t1_tt", bus.tt, 8'hEA);
    checkOutput("t1_pass", bus.pass, 1);
    checkOutput("t1_err_cnt", bus.err_cnt, 0);
    checkOutput("t1_first_err_valid", bus.first_err_valid, 0);

    $display("[TB] single mismatch, exp 8'hEB");
    applyStimulus(8'hEB);
    waitDone(lat, gotDone);
    checkOutput("t2_pass", bus.pass, 0);
    checkOutput("t2_err_cnt", bus.err_cnt, 1);
    checkOutput("t2_first_err_vec", bus.first_err_vec, 0);
    checkOutput("t2_first_err_valid", bus.first_err_valid, 1);

    $display("[TB] f tied low, exp 8'hFF, x stepping");
    fTiedLow = 1'b1;
    trackEn = 1'b1;
    applyStimulus(8'hFF);
    waitDone(lat, gotDone);
    checkOutput("t3_tt", bus.tt, 8'h00);
    checkOutput("t3_err_cnt", bus.err_cnt, 8);
    checkOutput("t3_first_err_vec", bus.first_err_vec, 0);
    checkOutput("t3_pass", bus.pass, 0);
    for (int i = 0; i < TT_W; i++) checkOutput($sformatf("t3_x%0d_cycles", i), runLen[i], HOLD);
    checkOutput("t3_x_steps", stepErr, 0);
    trackEn = 1'b0;

    $display("[TB] reset at cycle 50 of a sweep");
    applyStimulus(8'hFF);
    repeat (49) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkResetState("midrst");
    #1;
    rst = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) doneCount++;
    end
    checkOutput("t4_no_done", doneCount, 0);
    applyStimulus(8'hFF);
    waitDone(lat, gotDone);
    checkOutput("t4_latency", lat, SWEEP_LAT);
    checkOutput("t4_err_cnt", bus.err_cnt, 8);

    $display("[TB] start during sweep ignored");
    fTiedLow = 1'b0;
    applyStimulus(8'hEA);
    repeat (28) @(posedge clk);
    #2;
    bus.exp_tt = 8'h00;
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    waitDone(lat, gotDone);
    checkOutput("t5_pass", bus.pass, 1);
    checkOutput("t5_err_cnt", bus.err_cnt, 0);
    checkOutput("t5_tt", bus.tt, 8'hEA);

    $display("[TB] start together with reset");
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.exp_tt = 8'hEA;
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t6_busy", bus.busy, 0);
    checkOutput("t6_x", bus.x, 0);
    checkOutput("t6_pass", bus.pass, 0);

`ifdef TT_STABLE_CHECK_EN
    $display("[TB] glitch at hold count 10 of vector 5");
    applyStimulus(8'hEA);
    repeat (110) @(posedge clk);
    #2;
    fGlitch = 1'b1;
    @(posedge clk);
    #2;
    fGlitch = 1'b0;
    waitDone(lat, gotDone);
    checkOutput("t7_unstable", bus.unstable, 1);
    checkOutput("t7_err_cnt", bus.err_cnt, 1);
    checkOutput("t7_first_err_vec", bus.first_err_vec, 5);
    checkOutput("t7_pass", bus.pass, 0);
    checkOutput("t7_tt", bus.tt, 8'hEA);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
